// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between the CPU (port 0) and the loader (port 1).
// One access in flight: RAM strobed in ISSUE, ACK/RDATA returned in DONE; the port just served is masked for that cycle.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic [DW-1:0] RDATA0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA1,
  output logic          STALL,
  output logic          RAM_EN,
  output logic          RAM_WE,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_WDATA,
  input  logic [DW-1:0] RAM_RDATA
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic cand0, cand1, grant, win;

  // In DONE the port being acknowledged is still holding REQ; mask it so it is not served twice.
  assign cand0 = REQ0 & ~((state_q == DONE) & ~sel_q);
  assign cand1 = REQ1 & ~((state_q == DONE) &  sel_q);
  assign grant = cand0 | cand1;
  assign win   = (cand0 & cand1) ? ~last_q : cand1;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      ISSUE: begin
        state_d = DONE;
        last_d  = sel_q;
      end
      IDLE, DONE: begin
        if (grant) begin
          state_d     = ISSUE;
          sel_d       = win;
          ram_en_d    = 1'b1;
          ram_we_d    = win ? WE1    : WE0;
          ram_addr_d  = win ? ADDR1  : ADDR0;
          ram_wdata_d = win ? WDATA1 : WDATA0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LAST resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ACK0      = (state_q == DONE) & ~sel_q;
  assign ACK1      = (state_q == DONE) &  sel_q;
  assign RDATA0    = ACK0 ? RAM_RDATA : '0;
  assign RDATA1    = ACK1 ? RAM_RDATA : '0;
  assign STALL     = REQ0 & ~ACK0;
  assign RAM_EN    = ram_en_q;
  assign RAM_WE    = ram_we_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;

endmodule
